// File: rtl/sram_port_arbiter.sv
// Two-master arbiter sharing one sram-like port between instruction fetch and data.
// The data master has priority, a stalled grant is locked until accepted, and an owner FIFO routes responses.
module sram_port_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [2:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [2:0]  m_size,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        err_unexpected_ok
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam logic [PW:0]   DEPTH   = (PW+1)'(OUTSTANDING);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

    lock_state_e            state_q, state_d;
    logic                   owner_q, owner_d;
    logic [OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic                   err_q, err_d;

    logic full, grant_vld, grant_owner, grant_req, accept, push, pop, resp_owner;

    assign full = (count_q == DEPTH);

    // Grant: the locked owner first, then data over inst; with no grant the mux rests on data.
    always_comb begin
        grant_vld   = 1'b0;
        grant_owner = 1'b1;
        if (state_q == LOCKED) begin
            grant_vld   = 1'b1;
            grant_owner = owner_q;
        end else if (data_req) begin
            grant_vld   = 1'b1;
            grant_owner = 1'b1;
        end else if (inst_req) begin
            grant_vld   = 1'b1;
            grant_owner = 1'b0;
        end
    end

    assign grant_req = grant_owner ? data_req : inst_req;
    assign m_req     = grant_vld && grant_req && !full;
    assign m_wr      = grant_owner ? data_wr    : inst_wr;
    assign m_size    = grant_owner ? data_size  : inst_size;
    assign m_addr    = grant_owner ? data_addr  : inst_addr;
    assign m_wstrb   = grant_owner ? data_wstrb : inst_wstrb;
    assign m_wdata   = grant_owner ? data_wdata : inst_wdata;

    assign accept       = m_req && m_addr_ok;
    assign inst_addr_ok = accept && !grant_owner;
    assign data_addr_ok = accept && grant_owner;

    assign push       = accept;
    assign pop        = m_data_ok && (count_q != '0);
    assign resp_owner = fifo_q[rd_ptr_q];

    assign inst_data_ok      = pop && !resp_owner;
    assign data_data_ok      = pop && resp_owner;
    assign inst_rdata        = m_rdata;
    assign data_rdata        = m_rdata;
    assign err_unexpected_ok = err_q;

    // A stalled grant stays locked; while full m_req is low so the lock simply holds.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            UNLOCKED: begin
                if (m_req && !m_addr_ok) begin
                    state_d = LOCKED;
                    owner_d = grant_owner;
                end
            end
            LOCKED: begin
                if (accept) state_d = UNLOCKED;
            end
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = grant_owner;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        err_d = err_q || (m_data_ok && (count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= UNLOCKED;
            owner_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Owner bits are only meaningful below count, so they need no reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: per-cycle vector table, directed multi-cycle sequences,
// then random traffic compared against a queue-based model of the arbitration rules.
module tb_sram_port_arbiter;
    localparam logic [31:0] IA = 32'h1FC0_0000;
    localparam logic [31:0] DA = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [2:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [3:0]  inst_wstrb;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [2:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        m_req, m_wr, m_addr_ok, m_data_ok, err_unexpected_ok;
    logic [2:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    sram_port_arbiter #(.OUTSTANDING(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .err_unexpected_ok(err_unexpected_ok)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passes = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passes++;
    endtask

    task automatic apply(input logic rn, input logic ir, input logic dr, input logic aok,
                         input logic dok, input logic [31:0] rd);
        resetn = rn; inst_req = ir; data_req = dr;
        m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rn, ir, dr, aok, dok;
        logic [31:0] rd;
        logic emreq;
        logic [31:0] eaddr;
        logic [1:0] eaok, edok;
        logic eerr;
    } vec_t;

    function automatic vec_t mk(input logic rn, ir, dr, aok, dok, input logic [31:0] rd,
                                input logic emreq, input logic [31:0] ea,
                                input logic [1:0] eaok, edok, input logic eerr);
        vec_t v;
        v.rn = rn; v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd;
        v.emreq = emreq; v.eaddr = ea; v.eaok = eaok; v.edok = edok; v.eerr = eerr;
        return v;
    endfunction

    vec_t tbl[$];
    int   q[$];
    logic mlock, mown, merr, pi, pd, gv, g, emreq, acc, pop, full;
    logic [71:0] epay;

    initial begin
        inst_wr = 0; inst_size = 3'd2; inst_addr = IA; inst_wstrb = 4'hF; inst_wdata = 32'h0;
        data_wr = 1; data_size = 3'd2; data_addr = DA; data_wstrb = 4'h3; data_wdata = 32'hCAFE;
        apply(0, 0, 0, 0, 0, 0);
        tick();

        // {aok} and {dok} expectations are packed {inst, data}
        tbl.push_back(mk(0,0,0,0,0,0,            0,DA,2'b00,2'b00,0));
        tbl.push_back(mk(0,0,1,0,1,0,            1,DA,2'b00,2'b00,0));
        tbl.push_back(mk(1,0,0,0,0,0,            0,DA,2'b00,2'b00,0));
        tbl.push_back(mk(1,1,1,1,0,0,            1,DA,2'b01,2'b00,0));
        tbl.push_back(mk(1,1,0,1,0,0,            1,IA,2'b10,2'b00,0));
        tbl.push_back(mk(1,0,0,0,0,0,            0,DA,2'b00,2'b00,0));
        tbl.push_back(mk(1,0,0,0,1,32'h11111111, 0,DA,2'b00,2'b01,0));
        tbl.push_back(mk(1,0,0,0,1,32'h22222222, 0,DA,2'b00,2'b10,0));
        tbl.push_back(mk(1,1,0,0,0,0,            1,IA,2'b00,2'b00,0));
        tbl.push_back(mk(1,1,1,0,0,0,            1,IA,2'b00,2'b00,0));
        tbl.push_back(mk(1,1,1,0,0,0,            1,IA,2'b00,2'b00,0));
        tbl.push_back(mk(1,1,1,1,0,0,            1,IA,2'b10,2'b00,0));
        tbl.push_back(mk(1,0,1,1,0,0,            1,DA,2'b01,2'b00,0));
        tbl.push_back(mk(1,0,0,0,1,32'hA5A5A5A5, 0,DA,2'b00,2'b10,0));
        tbl.push_back(mk(1,0,0,0,1,32'h5A5A5A5A, 0,DA,2'b00,2'b01,0));
        tbl.push_back(mk(1,0,0,0,1,32'h0,        0,DA,2'b00,2'b00,0));
        tbl.push_back(mk(1,0,0,0,0,0,            0,DA,2'b00,2'b00,1));
        tbl.push_back(mk(1,0,0,0,0,0,            0,DA,2'b00,2'b00,1));
        tbl.push_back(mk(0,0,0,0,0,0,            0,DA,2'b00,2'b00,1));
        tbl.push_back(mk(1,0,0,0,0,0,            0,DA,2'b00,2'b00,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rn, tbl[i].ir, tbl[i].dr, tbl[i].aok, tbl[i].dok, tbl[i].rd);
            chk($sformatf("tbl%0d m_req", i), m_req, tbl[i].emreq);
            chk($sformatf("tbl%0d m_addr", i), m_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d addr_ok", i), {inst_addr_ok, data_addr_ok}, tbl[i].eaok);
            chk($sformatf("tbl%0d data_ok", i), {inst_data_ok, data_data_ok}, tbl[i].edok);
            chk($sformatf("tbl%0d err", i), err_unexpected_ok, tbl[i].eerr);
            if (tbl[i].edok[1]) chk($sformatf("tbl%0d inst_rdata", i), inst_rdata, tbl[i].rd);
            if (tbl[i].edok[0]) chk($sformatf("tbl%0d data_rdata", i), data_rdata, tbl[i].rd);
            tick();
        end

        // Fill to depth, stall, then pop-while-full without a same-cycle push
        for (int k = 0; k < 4; k++) begin
            apply(1, 0, 1, 1, 0, 0);
            chk($sformatf("fill%0d data_addr_ok", k), data_addr_ok, 1'b1);
            tick();
        end
        apply(1, 0, 1, 1, 0, 0);
        chk("full m_req", m_req, 1'b0);
        chk("full data_addr_ok", data_addr_ok, 1'b0);
        tick();
        apply(1, 0, 1, 1, 1, 32'h0BAD0001);
        chk("full_pop data_data_ok", data_data_ok, 1'b1);
        chk("full_pop m_req", m_req, 1'b0);
        chk("full_pop data_addr_ok", data_addr_ok, 1'b0);
        tick();
        apply(1, 0, 1, 1, 0, 0);
        chk("resume data_addr_ok", data_addr_ok, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(1, 0, 0, 0, 1, 32'(k));
            chk($sformatf("drain%0d data_ok", k), {inst_data_ok, data_data_ok}, 2'b01);
            tick();
        end

        // Alternating masters, each answered two cycles after its accept
        for (int k = 0; k < 12; k++) begin
            logic [1:0] eaok, edok;
            eaok = (k < 10) ? ((k % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
            edok = (k >= 2) ? ((k % 2 == 1) ? 2'b01 : 2'b10) : 2'b00;
            apply(1, (k < 10) && (k % 2 == 0), (k < 10) && (k % 2 == 1), k < 10, k >= 2, 32'(k));
            chk($sformatf("wrap%0d addr_ok", k), {inst_addr_ok, data_addr_ok}, eaok);
            chk($sformatf("wrap%0d data_ok", k), {inst_data_ok, data_data_ok}, edok);
            tick();
        end
        apply(1, 0, 0, 0, 0, 0);
        chk("wrap err", err_unexpected_ok, 1'b0);

        // Reset with three outstanding and inst locked
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 1, 1, 0, 0);
            tick();
        end
        apply(1, 1, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0, 0);
        tick();
        apply(1, 1, 1, 0, 0, 0);
        chk("rst lock cleared m_addr", m_addr, DA);
        chk("rst m_req", m_req, 1'b1);
        tick();
        apply(1, 0, 0, 0, 1, 32'h1);
        chk("rst data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        tick();
        apply(1, 0, 0, 0, 0, 0);
        chk("rst err set", err_unexpected_ok, 1'b1);

        // Random traffic against the reference model
        apply(0, 0, 0, 0, 0, 0);
        tick();
        mlock = 0; mown = 0; merr = 0; pi = 0; pd = 0;
        q.delete();
        for (int c = 0; c < 2000; c++) begin
            if (!pi && $urandom_range(1, 0) == 1) begin
                pi = 1; inst_wr = 1'($urandom); inst_size = 3'($urandom_range(2, 0));
                inst_addr = $urandom; inst_wstrb = 4'($urandom); inst_wdata = $urandom;
            end
            if (!pd && $urandom_range(2, 0) == 0) begin
                pd = 1; data_wr = 1'($urandom); data_size = 3'($urandom_range(2, 0));
                data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
            end
            apply(1, pi, pd, $urandom_range(3, 0) != 0,
                  (q.size() != 0) ? 1'($urandom) : ($urandom_range(49, 0) == 0), $urandom);

            full = (q.size() == 4);
            gv = 1; g = 1;
            if (mlock) g = mown;
            else if (pd) g = 1;
            else if (pi) g = 0;
            else gv = 0;
            emreq = gv && (g ? pd : pi) && !full;
            acc   = emreq && m_addr_ok;
            pop   = m_data_ok && (q.size() != 0);
            epay  = g ? {data_wr, data_size, data_addr, data_wstrb, data_wdata}
                      : {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};

            chk($sformatf("rnd%0d ctrl", c),
                {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexpected_ok},
                {emreq, acc && !g, acc && g, pop && q[0] == 0, pop && q[0] == 1, merr});
            chk($sformatf("rnd%0d payload", c), {m_wr, m_size, m_addr, m_wstrb, m_wdata}, epay);
            if (pop) chk($sformatf("rnd%0d rdata", c), q[0] ? data_rdata : inst_rdata, m_rdata);

            if (m_data_ok && q.size() == 0) merr = 1;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(int'(g));
                if (g) pd = 0; else pi = 0;
            end
            if (!mlock && emreq && !m_addr_ok) begin
                mlock = 1; mown = g;
            end else if (mlock && acc) begin
                mlock = 0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
